// File: rtl/icache_refill_scheduler.sv
// I-cache refill scheduler: arbitrates demand misses and prefetches onto one memory read port.
// Optional prefetch/merge path is enabled by defining ICACHE_REFILL_PREFETCH_EN.
module icache_refill_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  demandReq,
  input  logic [ADDR_WIDTH-1:0] demandAddr,
  output logic                  demandDone,
  input  logic                  pfReq,
  input  logic [ADDR_WIDTH-1:0] pfAddr,
  output logic                  pfAck,
  output logic                  memReq,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic                  memGrant,
  input  logic                  memRdValid,
  input  logic [BEAT_WIDTH-1:0] memRdData,
  output logic                  fillWE,
  output logic [ADDR_WIDTH-1:0] fillAddr,
  output logic [LINE_WIDTH-1:0] fillData,
  output logic                  busy
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam int CW    = $clog2(BEATS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] line_q;
  logic [ADDR_WIDTH-1:0] demand_line;
  logic [ADDR_WIDTH-1:0] pf_line;
  logic [LINE_WIDTH-1:0] line_buf;
  logic [CW-1:0]         cnt;
  logic                  src_pf;
  logic                  merge_q;
  logic                  merge_hit;
  logic                  take_pf;
  logic                  addr_unused;

  assign demand_line = {demandAddr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};

`ifdef ICACHE_REFILL_PREFETCH_EN
  assign pf_line     = {pfAddr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
  // Demand has priority; a prefetch is only taken from an idle, non-reset cycle.
  assign take_pf     = rst && (state == IDLE) && !demandReq && pfReq;
  assign merge_hit   = (state != IDLE) && src_pf && demandReq && (demand_line == line_q);
  assign addr_unused = ^{demandAddr[OFF-1:0], pfAddr[OFF-1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      src_pf  <= 1'b0;
      merge_q <= 1'b0;
    end else if (state == IDLE) begin
      src_pf  <= take_pf;
      merge_q <= 1'b0;
    end else if (merge_hit) begin
      merge_q <= 1'b1;
    end
  end
`else
  assign pf_line     = '0;
  assign take_pf     = 1'b0;
  assign merge_hit   = 1'b0;
  assign src_pf      = 1'b0;
  assign merge_q     = 1'b0;
  assign addr_unused = ^{demandAddr[OFF-1:0], pfReq, pfAddr};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      line_q   <= '0;
      line_buf <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (demandReq) begin
            line_q <= demand_line;
            state  <= REQ;
          end else if (take_pf) begin
            line_q <= pf_line;
            state  <= REQ;
          end
        end
        REQ: begin
          if (memGrant) begin
            cnt   <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (memRdValid) begin
            line_buf[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= memRdData;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(BEATS - 1)) state <= WRITE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign memReq     = (state == REQ);
  assign memAddr    = line_q;
  assign fillWE     = (state == WRITE);
  assign fillAddr   = line_q;
  assign fillData   = line_buf;
  assign busy       = (state != IDLE);
  assign pfAck      = take_pf;
  // A dropped demandReq (flush) suppresses completion even though the line is written.
  assign demandDone = (state == WRITE) && demandReq && (!src_pf || merge_q || merge_hit);

endmodule

// File: tb/tb_icache_refill_scheduler.sv
// Directed bench for icache_refill_scheduler (BEATS=4); prefetch scenarios depend on ICACHE_REFILL_PREFETCH_EN.
module tb_icache_refill_scheduler;
  logic         clk = 1'b0;
  logic         rst;
  logic         demandReq;
  logic [31:0]  demandAddr;
  logic         demandDone;
  logic         pfReq;
  logic [31:0]  pfAddr;
  logic         pfAck;
  logic         memReq;
  logic [31:0]  memAddr;
  logic         memGrant;
  logic         memRdValid;
  logic [63:0]  memRdData;
  logic         fillWE;
  logic [31:0]  fillAddr;
  logic [255:0] fillData;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  icache_refill_scheduler dut (
    .clk(clk), .rst(rst),
    .demandReq(demandReq), .demandAddr(demandAddr), .demandDone(demandDone),
    .pfReq(pfReq), .pfAddr(pfAddr), .pfAck(pfAck),
    .memReq(memReq), .memAddr(memAddr), .memGrant(memGrant),
    .memRdValid(memRdValid), .memRdData(memRdData),
    .fillWE(fillWE), .fillAddr(fillAddr), .fillData(fillData), .busy(busy)
  );

  // Inputs change at posedge+1; outputs are sampled at posedge+3.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; demandReq = 1'b1; demandAddr = 32'h1044; pfReq = 1'b1; pfAddr = 32'h3000;
    memGrant = 1'b0; memRdValid = 1'b0; memRdData = '0;
    nxt(); nxt(); #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (memReq !== 1'b0) begin bad++; $display("FAIL rst_memreq got=%b want=0", memReq); end
    total++; if (fillWE !== 1'b0 || demandDone !== 1'b0) begin bad++; $display("FAIL rst_fill got=%b%b want=00", fillWE, demandDone); end
    total++; if (pfAck !== 1'b0) begin bad++; $display("FAIL rst_pfack got=%b want=0", pfAck); end
    total++; if (memAddr !== 32'h0 || fillAddr !== 32'h0 || fillData !== 256'h0) begin bad++; $display("FAIL rst_data got=%h/%h want=0", memAddr, fillAddr); end
    demandReq = 1'b0; pfReq = 1'b0;
    nxt(); rst = 1'b1;
    nxt();
  endtask

  task automatic test_demand();
    logic [255:0] exp;
    exp = {64'h44, 64'h33, 64'h22, 64'h11};
    demandReq = 1'b1; demandAddr = 32'h1044; #2;
    total++; if (memReq !== 1'b0) begin bad++; $display("FAIL t2_c0_memreq got=%b want=0", memReq); end
    nxt(); memGrant = 1'b1; #2;
    total++; if (memReq !== 1'b1) begin bad++; $display("FAIL t2_c1_memreq got=%b want=1", memReq); end
    total++; if (memAddr !== 32'h1040) begin bad++; $display("FAIL t2_memaddr got=%h want=00001040", memAddr); end
    for (int k = 0; k < 4; k++) begin
      nxt(); memGrant = 1'b0; memRdValid = 1'b1; memRdData = 64'h11 * (k + 1); #2;
      total++; if (fillWE !== 1'b0 || memReq !== 1'b0) begin bad++; $display("FAIL t2_beat%0d got we=%b req=%b want 0 0", k, fillWE, memReq); end
    end
    nxt(); memRdValid = 1'b0; #2;
    total++; if (fillWE !== 1'b1) begin bad++; $display("FAIL t2_fillwe got=%b want=1", fillWE); end
    total++; if (demandDone !== 1'b1) begin bad++; $display("FAIL t2_done got=%b want=1", demandDone); end
    total++; if (fillAddr !== 32'h1040) begin bad++; $display("FAIL t2_filladdr got=%h want=00001040", fillAddr); end
    total++; if (fillData !== exp) begin bad++; $display("FAIL t2_filldata got=%h want=%h", fillData, exp); end
    demandReq = 1'b0;
    nxt(); #2;
    total++; if (busy !== 1'b0 || fillWE !== 1'b0) begin bad++; $display("FAIL t2_after got busy=%b we=%b want 0 0", busy, fillWE); end
  endtask

`ifdef ICACHE_REFILL_PREFETCH_EN
  task automatic test_priority();
    nxt(); demandReq = 1'b1; demandAddr = 32'h2000; pfReq = 1'b1; pfAddr = 32'h3000; #2;
    total++; if (pfAck !== 1'b0) begin bad++; $display("FAIL t3_c0_pfack got=%b want=0", pfAck); end
    nxt(); memGrant = 1'b1; #2;
    total++; if (memAddr !== 32'h2000 || memReq !== 1'b1) begin bad++; $display("FAIL t3_first_addr got=%h want=00002000", memAddr); end
    for (int k = 0; k < 4; k++) begin
      nxt(); memGrant = 1'b0; memRdValid = 1'b1; memRdData = 64'hA0 + 64'(k); #2;
      total++; if (pfAck !== 1'b0) begin bad++; $display("FAIL t3_pfack_fill%0d got=%b want=0", k, pfAck); end
    end
    nxt(); memRdValid = 1'b0; #2;
    total++; if (fillWE !== 1'b1 || demandDone !== 1'b1 || fillAddr !== 32'h2000) begin bad++; $display("FAIL t3_first_write got we=%b done=%b addr=%h want 1 1 00002000", fillWE, demandDone, fillAddr); end
    demandReq = 1'b0;
    nxt(); #2;
    total++; if (pfAck !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL t3_pfack_idle got ack=%b busy=%b want 1 0", pfAck, busy); end
    nxt(); pfReq = 1'b0; memGrant = 1'b1; #2;
    total++; if (memAddr !== 32'h3000 || memReq !== 1'b1) begin bad++; $display("FAIL t3_second_addr got=%h want=00003000", memAddr); end
    for (int k = 0; k < 4; k++) begin
      nxt(); memGrant = 1'b0; memRdValid = 1'b1; memRdData = 64'hB0 + 64'(k);
    end
    nxt(); memRdValid = 1'b0; #2;
    total++; if (fillWE !== 1'b1 || demandDone !== 1'b0 || fillAddr !== 32'h3000) begin bad++; $display("FAIL t3_second_write got we=%b done=%b addr=%h want 1 0 00003000", fillWE, demandDone, fillAddr); end
    nxt();
  endtask

  task automatic test_merge();
    nxt(); pfReq = 1'b1; pfAddr = 32'h4000; #2;
    total++; if (pfAck !== 1'b1) begin bad++; $display("FAIL t4_pfack got=%b want=1", pfAck); end
    nxt(); pfReq = 1'b0; memGrant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nxt(); memGrant = 1'b0; memRdValid = 1'b1; memRdData = 64'hC0 + 64'(k);
      if (k == 1) begin demandReq = 1'b1; demandAddr = 32'h4010; end
      #2;
      total++; if (memReq !== 1'b0) begin bad++; $display("FAIL t4_no_req%0d got=%b want=0", k, memReq); end
    end
    nxt(); memRdValid = 1'b0; #2;
    total++; if (fillWE !== 1'b1 || demandDone !== 1'b1) begin bad++; $display("FAIL t4_merge_done got we=%b done=%b want 1 1", fillWE, demandDone); end
    demandReq = 1'b0;
    nxt(); #2;
    total++; if (busy !== 1'b0 || memReq !== 1'b0) begin bad++; $display("FAIL t4_no_refetch got busy=%b req=%b want 0 0", busy, memReq); end
  endtask
`else
  task automatic test_pf_disabled();
    nxt(); pfReq = 1'b1; pfAddr = 32'h7000;
    for (int k = 0; k < 3; k++) begin
      nxt(); #2;
      total++; if (pfAck !== 1'b0 || busy !== 1'b0 || memReq !== 1'b0) begin bad++; $display("FAIL t3_pf_ignored%0d got ack=%b busy=%b req=%b want 0 0 0", k, pfAck, busy, memReq); end
    end
    pfReq = 1'b0;
  endtask
`endif

  task automatic test_flush();
    nxt(); demandReq = 1'b1; demandAddr = 32'h5008;
    nxt(); memGrant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nxt(); memGrant = 1'b0; memRdValid = 1'b1; memRdData = 64'hD0 + 64'(k);
      if (k == 2) demandReq = 1'b0;
    end
    nxt(); memRdValid = 1'b0; #2;
    total++; if (fillWE !== 1'b1 || fillAddr !== 32'h5000) begin bad++; $display("FAIL t5_fill got we=%b addr=%h want 1 00005000", fillWE, fillAddr); end
    total++; if (demandDone !== 1'b0) begin bad++; $display("FAIL t5_done got=%b want=0", demandDone); end
    nxt(); #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_idle got=%b want=0", busy); end
  endtask

  task automatic test_grant_stall();
    logic [255:0] exp;
    exp = {64'hA4, 64'hA3, 64'hA2, 64'hA1};
    nxt(); demandReq = 1'b1; demandAddr = 32'h6020;
    for (int k = 0; k < 10; k++) begin
      nxt();
      memRdValid = (k == 2); memRdData = 64'hDEAD;
      #2;
      total++; if (memReq !== 1'b1 || memAddr !== 32'h6020) begin bad++; $display("FAIL t6_stall%0d got req=%b addr=%h want 1 00006020", k, memReq, memAddr); end
    end
    nxt(); memRdValid = 1'b0; memGrant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nxt(); memGrant = 1'b0; memRdValid = 1'b1; memRdData = 64'hA1 + 64'(k); #2;
      total++; if (fillWE !== 1'b0) begin bad++; $display("FAIL t6_early_we%0d got=%b want=0", k, fillWE); end
    end
    nxt(); memRdValid = 1'b0; #2;
    total++; if (fillWE !== 1'b1 || demandDone !== 1'b1) begin bad++; $display("FAIL t6_write got we=%b done=%b want 1 1", fillWE, demandDone); end
    total++; if (fillData !== exp) begin bad++; $display("FAIL t6_data got=%h want=%h", fillData, exp); end
    demandReq = 1'b0;
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_demand();
`ifdef ICACHE_REFILL_PREFETCH_EN
    test_priority();
    test_merge();
`else
    test_pf_disabled();
`endif
    test_flush();
    test_grant_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
